// File: rtl/mctrl.sv
// mctrl: multi-cycle MIPS control FSM.
//
// Steps each instruction through FETCH / DECODE / execute / memory / write-back
// states and drives every register enable, mux select and memory strobe of the
// shared-memory multi-cycle datapath. Memory accesses wait on mem_ready; a
// watchdog aborts an access after 2^WAIT_W-1 consecutive not-ready cycles.
//
// Build option: define MCTRL_SHIFT_EN to add sll/srl/sra (R-type, shamt on
// ALUSrcA=10). Without it those Functs are illegal.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   Op, Funct          opcode / funct fields from the instruction register
//   Zero               ALU zero flag (used only in BRANCH)
//   mem_ready          memory has completed the current access
//   PCWrite, IRWrite, MemRead, MemWrite, RegWrite   strobes
//   IorD, EXTOp, ALUOp, ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel   datapath selects
//   illegal            one-cycle pulse on an undecodable instruction
//   bus_err            one-cycle pulse on memory timeout
//   state              current FSM state (debug)
module mctrl #(
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned WAIT_W  = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               IorD,
    output logic               EXTOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic               illegal,
    output logic               bus_err,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StExecI  = 4'd10
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [ALUOP_W-1:0] AluNop  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] AluAdd  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] AluSub  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] AluAnd  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] AluOr   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] AluSlt  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] AluSltu = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] AluNor  = ALUOP_W'(8);
`ifdef MCTRL_SHIFT_EN
    localparam logic [ALUOP_W-1:0] AluSll  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] AluSrl  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] AluSra  = ALUOP_W'(11);
`endif

    // Last count value before the watchdog fires: the abort happens in the
    // (2^WAIT_W-1)th consecutive not-ready cycle.
    localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'((2 ** WAIT_W) - 2);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                imm_q;   // ALUWB writes rt (I-type) rather than rd
    logic                wait_st;
    logic                timeout;
    logic [ALUOP_W-1:0]  f_alu;
    logic                f_valid;
    logic                f_shift;

    // R-type funct decode
    always_comb begin
        f_alu   = AluNop;
        f_valid = 1'b1;
        f_shift = 1'b0;
        case (Funct)
            6'b100000, 6'b100001: f_alu = AluAdd;
            6'b100010, 6'b100011: f_alu = AluSub;
            6'b100100:            f_alu = AluAnd;
            6'b100101:            f_alu = AluOr;
            6'b100111:            f_alu = AluNor;
            6'b101010:            f_alu = AluSlt;
            6'b101011:            f_alu = AluSltu;
`ifdef MCTRL_SHIFT_EN
            6'b000000: begin f_alu = AluSll; f_shift = 1'b1; end
            6'b000010: begin f_alu = AluSrl; f_shift = 1'b1; end
            6'b000011: begin f_alu = AluSra; f_shift = 1'b1; end
`endif
            default:              f_valid = 1'b0;
        endcase
    end

    // Watchdog: counts consecutive not-ready cycles in a memory-wait state.
    // Any state change implies mem_ready=1 or a timeout, both of which clear it.
    assign wait_st = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    assign timeout = wait_st && !mem_ready && (wait_q == WaitLast);
    assign wait_d  = (wait_st && !mem_ready && !timeout) ? wait_q + WAIT_W'(1) : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StFetch;
            wait_q  <= '0;
            imm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == StExec) begin
                imm_q <= 1'b0;
            end else if (state_q == StExecI) begin
                imm_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        IorD     = 1'b0;
        EXTOp    = 1'b0;
        ALUOp    = AluNop;
        ALUSrcA  = 2'b00;
        ALUSrcB  = 2'b00;
        PCSource = 2'b00;
        GPRSel   = 2'b00;
        WDSel    = 2'b00;
        illegal  = 1'b0;
        bus_err  = 1'b0;

        case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = AluAdd;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = StDecode;
                end else if (timeout) begin
                    // PC is untouched, so staying here re-fetches the same word
                    bus_err = 1'b1;
                end
            end
            StDecode: begin
                ALUSrcB = 2'b11;
                EXTOp   = 1'b1;
                ALUOp   = AluAdd;
                case (Op)
                    OpLw, OpSw:    state_d = StMemAdr;
                    OpAddi, OpOri: state_d = StExecI;
                    OpBeq, OpBne:  state_d = StBranch;
                    OpJ, OpJal:    state_d = StJump;
                    OpRtype: begin
                        if (f_valid) begin
                            state_d = StExec;
                        end else begin
                            illegal = 1'b1;
                            state_d = StFetch;
                        end
                    end
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                EXTOp   = 1'b1;
                ALUOp   = AluAdd;
                state_d = (Op == OpSw) ? StMemWr : (Op == OpLw) ? StMemRd : StFetch;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = StMemWb;
                end else if (timeout) begin
                    bus_err = 1'b1;
                    state_d = StFetch;
                end
            end
            StMemWb: begin
                RegWrite = 1'b1;
                GPRSel   = 2'b01;
                WDSel    = 2'b01;
                state_d  = StFetch;
            end
            StMemWr: begin
                IorD = 1'b1;
                if (mem_ready) begin
                    MemWrite = 1'b1;
                    state_d  = StFetch;
                end else if (timeout) begin
                    // aborted store: drop the write strobe in the abort cycle
                    bus_err = 1'b1;
                    state_d = StFetch;
                end else begin
                    MemWrite = 1'b1;
                end
            end
            StExec: begin
                ALUSrcA = f_shift ? 2'b10 : 2'b01;
                ALUOp   = f_alu;
                state_d = StAluWb;
            end
            StExecI: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                if (Op == OpOri) begin
                    ALUOp = AluOr;
                end else begin
                    EXTOp = 1'b1;
                    ALUOp = AluAdd;
                end
                state_d = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                GPRSel   = imm_q ? 2'b01 : 2'b00;
                state_d  = StFetch;
            end
            StBranch: begin
                ALUSrcA  = 2'b01;
                ALUOp    = AluSub;
                PCSource = 2'b01;
                PCWrite  = ((Op == OpBeq) && Zero) || ((Op == OpBne) && !Zero);
                state_d  = StFetch;
            end
            StJump: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                if (Op == OpJal) begin
                    RegWrite = 1'b1;
                    GPRSel   = 2'b10;
                    WDSel    = 2'b10;
                end
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // While in reset the FSM sits in FETCH; suppress every strobe and pulse
        if (!rstn) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
            bus_err  = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mctrl.sv
module tb_mctrl;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
    logic       IorD, EXTOp;
    logic [3:0] ALUOp;
    logic [1:0] ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel;
    logic       illegal, bus_err;
    logic [3:0] state;

    int unsigned n_run  = 0;
    int unsigned n_fail = 0;

    mctrl #(
        .ALUOP_W (4),
        .WAIT_W  (3)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .Op        (Op),
        .Funct     (Funct),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .IorD      (IorD),
        .EXTOp     (EXTOp),
        .ALUOp     (ALUOp),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .PCSource  (PCSource),
        .GPRSel    (GPRSel),
        .WDSel     (WDSel),
        .illegal   (illegal),
        .bus_err   (bus_err),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // from FETCH with mem_ready=1: load a new instruction and land in DECODE
    task automatic enter_decode(input logic [5:0] op, input logic [5:0] fn);
        Op    = op;
        Funct = fn;
        #1;
        check("fetch_state", 32'(state), 32'd0);
        step();
        check("decode_state", 32'(state), 32'd1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb_mctrl time limit");
    end

    initial begin
        rstn = 1'b0; Op = OP_LW; Funct = 6'd0; Zero = 1'b0; mem_ready = 1'b1;
        #12;
        // reset: FETCH selects, strobes forced low
        check("rst_state", 32'(state), 32'd0);
        check("rst_memread", 32'(MemRead), 32'd0);
        check("rst_irwrite", 32'(IRWrite), 32'd0);
        check("rst_pcwrite", 32'(PCWrite), 32'd0);
        check("rst_alusrcb", 32'(ALUSrcB), 32'd1);
        check("rst_aluop", 32'(ALUOp), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        #1;

        // lw, mem_ready=1: 0,1,2,3,4,0
        check("lw_f_ir", 32'(IRWrite), 32'd1);
        check("lw_f_pcw", 32'(PCWrite), 32'd1);
        check("lw_f_mr", 32'(MemRead), 32'd1);
        step(); check("lw_s1", 32'(state), 32'd1);
        check("lw_dec_srcb", 32'(ALUSrcB), 32'd3);
        check("lw_dec_ext", 32'(EXTOp), 32'd1);
        step(); check("lw_s2", 32'(state), 32'd2);
        check("lw_adr_srca", 32'(ALUSrcA), 32'd1);
        check("lw_adr_srcb", 32'(ALUSrcB), 32'd2);
        step(); check("lw_s3", 32'(state), 32'd3);
        check("lw_rd_iord", 32'(IorD), 32'd1);
        check("lw_rd_mr", 32'(MemRead), 32'd1);
        step(); check("lw_s4", 32'(state), 32'd4);
        check("lw_wb_rw", 32'(RegWrite), 32'd1);
        check("lw_wb_gpr", 32'(GPRSel), 32'd1);
        check("lw_wb_wd", 32'(WDSel), 32'd1);
        step(); check("lw_s0", 32'(state), 32'd0);

        // beq taken and not taken
        for (int z = 1; z >= 0; z--) begin
            Zero = z[0];
            enter_decode(OP_BEQ, 6'd0);
            step(); check("beq_state", 32'(state), 32'd8);
            check("beq_pcw", 32'(PCWrite), 32'(z));
            check("beq_pcsrc", 32'(PCSource), 32'd1);
            check("beq_aluop", 32'(ALUOp), 32'd2);
            step(); check("beq_ret", 32'(state), 32'd0);
        end
        // bne with Zero=0 is taken
        Zero = 1'b0;
        enter_decode(OP_BNE, 6'd0);
        step(); check("bne_pcw", 32'(PCWrite), 32'd1);
        step();

        // fetch wait of 3 cycles, then j
        Op = OP_J; mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("fw_state", 32'(state), 32'd0);
            check("fw_ir", 32'(IRWrite), 32'd0);
            check("fw_pcw", 32'(PCWrite), 32'd0);
            step();
        end
        mem_ready = 1'b1;
        #1;
        check("fw_ir_go", 32'(IRWrite), 32'd1);
        check("fw_pcw_go", 32'(PCWrite), 32'd1);
        step(); check("fw_dec", 32'(state), 32'd1);
        step(); check("j_state", 32'(state), 32'd9);
        check("j_pcw", 32'(PCWrite), 32'd1);
        check("j_pcsrc", 32'(PCSource), 32'd2);
        check("j_rw", 32'(RegWrite), 32'd0);
        step(); check("j_ret", 32'(state), 32'd0);

        // lw timeout in MEMRD (WAIT_W=3: abort in 7th not-ready cycle)
        enter_decode(OP_LW, 6'd0);
        step(); check("to_adr", 32'(state), 32'd2);
        mem_ready = 1'b0;
        step();
        for (int i = 1; i <= 7; i++) begin
            check("to_state", 32'(state), 32'd3);
            check("to_buserr", 32'(bus_err), 32'(i == 7));
            check("to_rw", 32'(RegWrite), 32'd0);
            step();
        end
        check("to_ret", 32'(state), 32'd0);
        check("to_buserr_off", 32'(bus_err), 32'd0);

        // fetch timeout: stays in FETCH, counter restarts
        for (int i = 1; i <= 8; i++) begin
            check("fto_state", 32'(state), 32'd0);
            check("fto_buserr", 32'(bus_err), 32'(i == 7));
            check("fto_ir", 32'(IRWrite), 32'd0);
            step();
        end
        mem_ready = 1'b1;

        // sw with two wait cycles
        enter_decode(OP_SW, 6'd0);
        step();
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            check("sw_state", 32'(state), 32'd5);
            check("sw_mw", 32'(MemWrite), 32'd1);
            check("sw_iord", 32'(IorD), 32'd1);
            step();
        end
        mem_ready = 1'b1;
        #1;
        check("sw_mw_go", 32'(MemWrite), 32'd1);
        step(); check("sw_ret", 32'(state), 32'd0);

        // illegal opcode
        enter_decode(6'b111111, 6'd0);
        check("ill_pulse", 32'(illegal), 32'd1);
        step(); check("ill_ret", 32'(state), 32'd0);
        check("ill_off", 32'(illegal), 32'd0);

        // jal
        enter_decode(OP_JAL, 6'd0);
        step(); check("jal_state", 32'(state), 32'd9);
        check("jal_pcw", 32'(PCWrite), 32'd1);
        check("jal_rw", 32'(RegWrite), 32'd1);
        check("jal_gpr", 32'(GPRSel), 32'd2);
        check("jal_wd", 32'(WDSel), 32'd2);
        step();

        // R-type add, sub
        enter_decode(OP_R, 6'b100000);
        check("add_ill", 32'(illegal), 32'd0);
        step(); check("add_state", 32'(state), 32'd6);
        check("add_aluop", 32'(ALUOp), 32'd1);
        check("add_srca", 32'(ALUSrcA), 32'd1);
        check("add_srcb", 32'(ALUSrcB), 32'd0);
        step(); check("add_wb", 32'(state), 32'd7);
        check("add_rw", 32'(RegWrite), 32'd1);
        check("add_gpr", 32'(GPRSel), 32'd0);
        step();
        enter_decode(OP_R, 6'b100010);
        step(); check("sub_aluop", 32'(ALUOp), 32'd2);
        step(); step();

        // addi, ori
        enter_decode(OP_ADDI, 6'd0);
        step(); check("addi_state", 32'(state), 32'd10);
        check("addi_aluop", 32'(ALUOp), 32'd1);
        check("addi_ext", 32'(EXTOp), 32'd1);
        check("addi_srcb", 32'(ALUSrcB), 32'd2);
        step(); check("addi_gpr", 32'(GPRSel), 32'd1);
        check("addi_rw", 32'(RegWrite), 32'd1);
        step();
        enter_decode(OP_ORI, 6'd0);
        step(); check("ori_aluop", 32'(ALUOp), 32'd4);
        check("ori_ext", 32'(EXTOp), 32'd0);
        step(); check("ori_gpr", 32'(GPRSel), 32'd1);
        step();

        // srl
        enter_decode(OP_R, 6'b000010);
`ifdef MCTRL_SHIFT_EN
        check("srl_ill", 32'(illegal), 32'd0);
        step(); check("srl_state", 32'(state), 32'd6);
        check("srl_srca", 32'(ALUSrcA), 32'd2);
        check("srl_aluop", 32'(ALUOp), 32'd10);
        step(); step();
`else
        check("srl_ill", 32'(illegal), 32'd1);
        step(); check("srl_ret", 32'(state), 32'd0);
`endif

        // reset mid-instruction aborts at once
        enter_decode(OP_LW, 6'd0);
        step(); step();
        check("mr_pre", 32'(state), 32'd3);
        rstn = 1'b0;
        #1;
        check("mr_state", 32'(state), 32'd0);
        check("mr_mr", 32'(MemRead), 32'd0);
        check("mr_ir", 32'(IRWrite), 32'd0);
        check("mr_iord", 32'(IorD), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step(); check("mr_resume", 32'(state), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
